// File: rtl/spi_command_rx_if.sv
// Serial command bus between a PSRAM command transmitter and spi_command_rx.
// The master drives line/ce_n; the slave returns the decoded byte stream and
// the tracked device state.
interface spi_command_rx_if #(parameter int DATA_W = 8);
  logic              line;
  logic              ce_n;
  logic [DATA_W-1:0] byte_out;
  logic              byte_valid;
  logic              first_byte;
  logic              rst_armed;
  logic              psram_reset;
  logic              qpi_mode;
  logic              cmd_ignored;
  logic              frame_error;

  modport master (
    output line, ce_n,
    input  byte_out, byte_valid, first_byte, rst_armed,
           psram_reset, qpi_mode, cmd_ignored, frame_error
  );

  modport slave (
    input  line, ce_n,
    output byte_out, byte_valid, first_byte, rst_armed,
           psram_reset, qpi_mode, cmd_ignored, frame_error
  );
endinterface

// File: rtl/spi_command_rx.sv
// spi_command_rx: single-line PSRAM command receiver.
// Samples line MSB-first while ce_n is low, assembles DATA_W-bit bytes and
// decodes the first byte of each frame as an opcode (RSTEN/RST/QPI).
// Optional macro SPI_RX_SYNC_EN: inserts a 2-flop synchronizer on line/ce_n
// for asynchronous sources; all output latencies grow by 2 cycles.
module spi_command_rx #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] CMD_RSTEN = 8'h66,
  parameter logic [DATA_W-1:0] CMD_RST   = 8'h99,
  parameter logic [DATA_W-1:0] CMD_QPI   = 8'h35
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_command_rx_if.slave    bus
);
  localparam int             CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic line_s, ce_s;

`ifdef SPI_RX_SYNC_EN
  logic [1:0] line_sync, ce_sync;
  // Two-stage synchronizer; ce_n resets to the inactive (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_sync <= 2'b00;
      ce_sync   <= 2'b11;
    end else begin
      line_sync <= {line_sync[0], bus.line};
      ce_sync   <= {ce_sync[0], bus.ce_n};
    end
  end
  assign line_s = line_sync[1];
  assign ce_s   = ce_sync[1];
`else
  assign line_s = bus.line;
  assign ce_s   = bus.ce_n;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shifter;
  logic [CNT_W-1:0]  bit_ctr;
  logic              data_phase;   // set once the frame's opcode byte is done
  logic [DATA_W-1:0] next_byte;
  logic              byte_done, frame_end;

  logic [DATA_W-1:0] byte_q;
  logic              valid_q, first_q, armed_q, reset_q, qpi_q, ign_q, ferr_q;

  assign next_byte = {shifter[DATA_W-2:0], line_s};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-edge strobes; a low sample in IDLE already carries the MSB.
  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ce_s) begin
          state_d   = SHIFT;
          byte_done = (bit_ctr == LAST);
        end
      end
      SHIFT: begin
        if (ce_s) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end else begin
          byte_done = (bit_ctr == LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shifter, byte assembly, opcode decode and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter    <= '0;
      bit_ctr    <= '0;
      data_phase <= 1'b0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      armed_q    <= 1'b0;
      reset_q    <= 1'b0;
      qpi_q      <= 1'b0;
      ign_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      reset_q <= 1'b0;
      ign_q   <= 1'b0;
      ferr_q  <= 1'b0;

      if (!ce_s) begin
        shifter <= next_byte;
        bit_ctr <= byte_done ? '0 : bit_ctr + 1'b1;
      end

      if (byte_done) begin
        byte_q     <= next_byte;
        valid_q    <= 1'b1;
        first_q    <= !data_phase;
        data_phase <= 1'b1;
        if (!data_phase) begin
          if (next_byte == CMD_RSTEN) begin
            armed_q <= 1'b1;
          end else if (next_byte == CMD_RST) begin
            if (armed_q) begin
              reset_q <= 1'b1;
              qpi_q   <= 1'b0;
              armed_q <= 1'b0;
            end else begin
              ign_q   <= 1'b1;
            end
          end else if (next_byte == CMD_QPI) begin
            qpi_q   <= 1'b1;
            armed_q <= 1'b0;
          end else begin
            ign_q   <= 1'b1;
            armed_q <= 1'b0;
          end
        end
      end

      // Frame close: a partial byte is dropped without touching decode state.
      if (frame_end) begin
        ferr_q     <= (bit_ctr != '0);
        bit_ctr    <= '0;
        shifter    <= '0;
        data_phase <= 1'b0;
      end
    end
  end

  assign bus.byte_out    = byte_q;
  assign bus.byte_valid  = valid_q;
  assign bus.first_byte  = first_q;
  assign bus.rst_armed   = armed_q;
  assign bus.psram_reset = reset_q;
  assign bus.qpi_mode    = qpi_q;
  assign bus.cmd_ignored = ign_q;
  assign bus.frame_error = ferr_q;
endmodule

// File: tb/tb_spi_command_rx.sv
// Directed bench for spi_command_rx: reset state, output latency, back-to-back
// frames, a table of command frames, and a mid-frame reset.
module tb_spi_command_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  spi_command_rx_if #(.DATA_W(8)) bus ();
  spi_command_rx #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Output monitor: accumulates pulse counts, sampled mid-cycle.
  int         cnt_bv = 0, cnt_rst = 0, cnt_ign = 0, cnt_fe = 0, cnt_co = 0;
  logic [7:0] fb_hist = '0;
  always @(negedge clk) begin
    if (bus.byte_valid) begin
      cnt_bv  = cnt_bv + 1;
      fb_hist = {fb_hist[6:0], bus.first_byte};
    end
    if (bus.psram_reset) cnt_rst = cnt_rst + 1;
    if (bus.psram_reset && bus.byte_valid) cnt_co = cnt_co + 1;
    if (bus.cmd_ignored) cnt_ign = cnt_ign + 1;
    if (bus.frame_error) cnt_fe = cnt_fe + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive nbits of data MSB-first with ce_n low, then one high cycle.
  task automatic send_frame(input logic [15:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ce_n = 1'b0;
      bus.line = data[nbits-1-i];
    end
    @(negedge clk);
    bus.ce_n = 1'b1;
    bus.line = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    int          nbits;
    logic [7:0]  exp_byte;
    int          exp_nv, exp_rst, exp_ign, exp_fe;
    logic        exp_armed, exp_qpi;
    logic [1:0]  exp_fb;
  } vec_t;

  vec_t vecs[11];
  int   b_bv, b_rst, b_ign, b_fe, b_co;

  task automatic snap();
    b_bv = cnt_bv; b_rst = cnt_rst; b_ign = cnt_ign; b_fe = cnt_fe; b_co = cnt_co;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //             data    nb  byte  nv rst ign fe arm qpi fb
    vecs[0]  = '{16'h0099, 8, 8'h99, 1, 0, 1, 0, 1'b0, 1'b0, 2'b01};
    vecs[1]  = '{16'h0035, 8, 8'h35, 1, 0, 0, 0, 1'b0, 1'b1, 2'b01};
    vecs[2]  = '{16'h0066, 8, 8'h66, 1, 0, 0, 0, 1'b1, 1'b1, 2'b01};
    vecs[3]  = '{16'h0099, 8, 8'h99, 1, 1, 0, 0, 1'b0, 1'b0, 2'b01};
    vecs[4]  = '{16'h35A5, 16, 8'hA5, 2, 0, 0, 0, 1'b0, 1'b1, 2'b10};
    vecs[5]  = '{16'h0066, 8, 8'h66, 1, 0, 0, 0, 1'b1, 1'b1, 2'b01};
    vecs[6]  = '{16'h0015, 5, 8'h66, 0, 0, 0, 1, 1'b1, 1'b1, 2'b01};
    vecs[7]  = '{16'h0012, 8, 8'h12, 1, 0, 1, 0, 1'b0, 1'b1, 2'b01};
    vecs[8]  = '{16'h0035, 8, 8'h35, 1, 0, 0, 0, 1'b0, 1'b1, 2'b01};
    vecs[9]  = '{16'h0066, 8, 8'h66, 1, 0, 0, 0, 1'b1, 1'b1, 2'b01};
    vecs[10] = '{16'h0066, 8, 8'h66, 1, 0, 0, 0, 1'b1, 1'b1, 2'b01};

    bus.ce_n = 1'b1;
    bus.line = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.byte_out, bus.byte_valid, bus.first_byte, bus.rst_armed,
        bus.psram_reset, bus.qpi_mode, bus.cmd_ignored, bus.frame_error}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: byte_valid exactly LAT cycles after the last low sample.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.ce_n = 1'b0;
      bus.line = (i == 1 || i == 2 || i == 5 || i == 6);  // 0x66
    end
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      chk($sformatf("lat_bv_c%0d", c), {31'd0, bus.byte_valid}, {31'd0, c == LAT});
      @(negedge clk);
      bus.ce_n = 1'b1;
      bus.line = 1'b0;
    end
    chk("lat_first_byte", {31'd0, bus.first_byte}, 32'd1);
    chk("lat_byte_out", {24'd0, bus.byte_out}, 32'h66);
    @(posedge clk); #1;
    chk("lat_bv_width", {31'd0, bus.byte_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("lat_armed", {31'd0, bus.rst_armed}, 32'd1);

    // Back-to-back RSTEN, RST with a single high cycle between frames.
    snap();
    send_frame(16'h0066, 8);
    send_frame(16'h0099, 8);
    repeat (5) @(negedge clk);
    chk("b2b_nvalid", cnt_bv - b_bv, 32'd2);
    chk("b2b_reset", cnt_rst - b_rst, 32'd1);
    chk("b2b_reset_aligned", cnt_co - b_co, 32'd1);
    chk("b2b_armed_qpi", {30'd0, bus.rst_armed, bus.qpi_mode}, 32'd0);

    for (int v = 0; v < 11; v++) begin
      snap();
      send_frame(vecs[v].data, vecs[v].nbits);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_byte", v), {24'd0, bus.byte_out}, {24'd0, vecs[v].exp_byte});
      chk($sformatf("v%0d_nvalid", v), cnt_bv - b_bv, vecs[v].exp_nv);
      chk($sformatf("v%0d_reset", v), cnt_rst - b_rst, vecs[v].exp_rst);
      chk($sformatf("v%0d_reset_aligned", v), cnt_co - b_co, vecs[v].exp_rst);
      chk($sformatf("v%0d_ignored", v), cnt_ign - b_ign, vecs[v].exp_ign);
      chk($sformatf("v%0d_frame_err", v), cnt_fe - b_fe, vecs[v].exp_fe);
      chk($sformatf("v%0d_armed", v), {31'd0, bus.rst_armed}, {31'd0, vecs[v].exp_armed});
      chk($sformatf("v%0d_qpi", v), {31'd0, bus.qpi_mode}, {31'd0, vecs[v].exp_qpi});
      if (vecs[v].exp_nv == 2)
        chk($sformatf("v%0d_first_seq", v), {30'd0, fb_hist[1:0]}, {30'd0, vecs[v].exp_fb});
      else if (vecs[v].exp_nv == 1)
        chk($sformatf("v%0d_first", v), {31'd0, fb_hist[0]}, {31'd0, vecs[v].exp_fb[0]});
    end

    // Reset in the middle of a QPI frame (after 4 bits), then an unarmed RST.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ce_n = 1'b0;
      bus.line = (i >= 2);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.byte_out, bus.byte_valid, bus.first_byte, bus.rst_armed,
        bus.psram_reset, bus.qpi_mode, bus.cmd_ignored, bus.frame_error}, 32'h0);
    bus.ce_n = 1'b1;
    bus.line = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    send_frame(16'h0099, 8);
    repeat (5) @(negedge clk);
    chk("post_rst_ignored", cnt_ign - b_ign, 32'd1);
    chk("post_rst_no_reset", cnt_rst - b_rst, 32'd0);
    chk("post_rst_no_ferr", cnt_fe - b_fe, 32'd0);
    chk("post_rst_byte", {24'd0, bus.byte_out}, 32'h99);
    chk("post_rst_first", {31'd0, fb_hist[0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
